// File: rtl/gaplus_input_cond.sv
// Frame-synchronous input conditioner: per-bit debounce on frame ticks and a shaped coin pulse
// with a small credit queue. Define GAPLUS_AUTOFIRE_EN to add the AFIRE port and autofire.
module gaplus_input_cond #(
  parameter int unsigned DEB_LEN  = 4,
  parameter int unsigned COIN_ON  = 6,
  parameter int unsigned COIN_OFF = 6
`ifdef GAPLUS_AUTOFIRE_EN
  ,
  parameter int unsigned AF_RATE  = 4
`endif
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       VBLK,
  input  logic [4:0] JOY1,
  input  logic [4:0] JOY2,
  input  logic [1:0] START,
  input  logic [1:0] COIN,
`ifdef GAPLUS_AUTOFIRE_EN
  input  logic [1:0] AFIRE,
`endif
  output logic [4:0] INP0,
  output logic [4:0] INP1,
  output logic [2:0] INP2,
  output logic       FTICK
);

  localparam logic [3:0] DebLast     = 4'(DEB_LEN - 1);
  localparam logic [5:0] CoinOnLast  = 6'(COIN_ON - 1);
  localparam logic [5:0] CoinOffLast = 6'(COIN_OFF - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_st_e;

  logic             vblk_q, ftick_q;
  logic [11:0]      raw;
  logic [11:0]      stable_q, stable_d;
  logic [11:0][3:0] deb_cnt_q, deb_cnt_d;
  coin_st_e         coin_st_q, coin_st_d;
  logic [5:0]       coin_cnt_q, coin_cnt_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       coin_h_q, coin_h_d;
  logic [1:0]       coin_edge, nedge;
  logic [2:0]       pend_sum, pend_net;
  logic             pend_dec;
  logic [1:0]       trig_out;

  assign raw = {START, JOY2, JOY1};

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    if (ftick_q) begin
      for (int i = 0; i < 12; i++) begin
        if (raw[i] == stable_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          stable_d[i]  = raw[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign coin_edge = COIN & ~coin_h_q;
  assign nedge     = {1'b0, coin_edge[0]} + {1'b0, coin_edge[1]};
  assign pend_sum  = {1'b0, pending_q} + {1'b0, nedge};

  always_comb begin
    coin_st_d  = coin_st_q;
    coin_cnt_d = coin_cnt_q;
    pending_d  = pending_q;
    coin_h_d   = coin_h_q;
    pend_dec   = 1'b0;
    pend_net   = '0;
    if (ftick_q) begin
      coin_h_d = COIN;
      case (coin_st_q)
        StIdle: begin
          if (nedge != 2'd0) begin
            coin_st_d  = StPulse;
            coin_cnt_d = CoinOnLast;
            pend_dec   = 1'b1;
          end
        end
        StPulse: begin
          if (coin_cnt_q == 6'd0) begin
            coin_st_d  = StGap;
            coin_cnt_d = CoinOffLast;
          end else begin
            coin_cnt_d = coin_cnt_q - 6'd1;
          end
        end
        StGap: begin
          if (coin_cnt_q != 6'd0) begin
            coin_cnt_d = coin_cnt_q - 6'd1;
          end else if (pend_sum != 3'd0) begin
            // Credits arriving on the exit tick count towards the next pulse.
            coin_st_d  = StPulse;
            coin_cnt_d = CoinOnLast;
            pend_dec   = 1'b1;
          end else begin
            coin_st_d = StIdle;
          end
        end
        default: coin_st_d = StIdle;
      endcase
      pend_net  = pend_sum - {2'b00, pend_dec};
      pending_d = (pend_net > 3'd3) ? 2'd3 : pend_net[1:0];
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      vblk_q     <= 1'b0;
      ftick_q    <= 1'b0;
      stable_q   <= '0;
      deb_cnt_q  <= '0;
      coin_st_q  <= StIdle;
      coin_cnt_q <= '0;
      pending_q  <= '0;
      coin_h_q   <= '0;
    end else begin
      vblk_q     <= VBLK;
      ftick_q    <= VBLK & ~vblk_q;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      coin_st_q  <= coin_st_d;
      coin_cnt_q <= coin_cnt_d;
      pending_q  <= pending_d;
      coin_h_q   <= coin_h_d;
    end
  end

`ifdef GAPLUS_AUTOFIRE_EN
  localparam logic [3:0] AfLast = 4'(AF_RATE - 1);

  logic [1:0]      trig_d;
  logic [1:0]      af_out_q, af_out_d, af_run_q, af_run_d;
  logic [1:0][3:0] af_cnt_q, af_cnt_d;

  assign trig_d = {stable_d[9], stable_d[4]};

  always_comb begin
    af_out_d = af_out_q;
    af_run_d = af_run_q;
    af_cnt_d = af_cnt_q;
    if (ftick_q) begin
      for (int p = 0; p < 2; p++) begin
        if (AFIRE[p] && trig_d[p]) begin
          if (!af_run_q[p]) begin
            af_run_d[p] = 1'b1;
            af_out_d[p] = 1'b1;
            af_cnt_d[p] = '0;
          end else if (af_cnt_q[p] == AfLast) begin
            af_cnt_d[p] = '0;
            af_out_d[p] = ~af_out_q[p];
          end else begin
            af_cnt_d[p] = af_cnt_q[p] + 4'd1;
          end
        end else begin
          af_run_d[p] = 1'b0;
          af_cnt_d[p] = '0;
          af_out_d[p] = AFIRE[p] ? 1'b0 : trig_d[p];
        end
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      af_out_q <= '0;
      af_run_q <= '0;
      af_cnt_q <= '0;
    end else begin
      af_out_q <= af_out_d;
      af_run_q <= af_run_d;
      af_cnt_q <= af_cnt_d;
    end
  end

  assign trig_out = af_out_q;
`else
  assign trig_out = {stable_q[9], stable_q[4]};
`endif

  assign INP0  = {trig_out[0], stable_q[3:0]};
  assign INP1  = {trig_out[1], stable_q[8:5]};
  assign INP2  = {coin_st_q == StPulse, stable_q[11:10]};
  assign FTICK = ftick_q;

endmodule
